data_memory_ws: RTL

// - Parametrised successor to the single-cycle data RAM: word-organised, byte-addressed data memory

---
 rtl/data_memory_ws.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_ws.sv
// Word-organised, byte-addressed data memory with a valid/ready request port and configurable wait states.
// Optional feature: define DATA_MEM_MISALIGN_EN to fault misaligned H/HU/W accesses instead of truncating.
module data_memory_ws #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q;
    logic [2:0]         size_q;
    logic [31:0]        addr_q, wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

`ifndef SYNTHESIS
    logic [31:0]        mem_q [DEPTH] = '{default: '0};
`else
    logic [31:0]        mem_q [DEPTH];
`endif

    logic               accept, access;
    logic               c_we;
    logic [2:0]         c_size;
    logic [31:0]        c_addr, c_wdata;
    logic               oor, bad_size, misal, fault;
    logic [ADDR_W-1:0]  widx;
    logic [1:0]         off;
    logic [31:0]        word, lane_sh, load_val, wmask, wdata_sh;

    assign accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the access happens on the accept edge, so the live request is used directly.
    always_comb begin
        c_we    = we_q;
        c_size  = size_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_size  = req_size;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end
    end

    assign access = (accept && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q == '0));

    assign oor = |c_addr[31:ADDR_W+2];

    always_comb begin
        if (c_we) bad_size = !(c_size inside {3'b000, 3'b001, 3'b010});
        else      bad_size = !(c_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

`ifdef DATA_MEM_MISALIGN_EN
    assign misal = ((c_size[1:0] == 2'b01) && c_addr[0]) ||
                   ((c_size[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign fault = oor || bad_size || misal;
    assign widx  = c_addr[ADDR_W+1:2];
    assign word  = mem_q[widx];

    always_comb begin
        off = c_addr[1:0];
        if (c_size[1:0] == 2'b01) off = {c_addr[1], 1'b0};
        else if (c_size[1:0] == 2'b10) off = 2'b00;
    end

    assign lane_sh = word >> {off, 3'b000};

    always_comb begin
        case (c_size)
            3'b000:  load_val = {{24{lane_sh[7]}}, lane_sh[7:0]};
            3'b100:  load_val = {24'h0, lane_sh[7:0]};
            3'b001:  load_val = {{16{lane_sh[15]}}, lane_sh[15:0]};
            3'b101:  load_val = {16'h0, lane_sh[15:0]};
            default: load_val = lane_sh;
        endcase
    end

    always_comb begin
        case (c_size[1:0])
            2'b00:   wmask = 32'h0000_00FF << {off, 3'b000};
            2'b01:   wmask = 32'h0000_FFFF << {off, 3'b000};
            default: wmask = '1;
        endcase
        wdata_sh = c_wdata << {off, 3'b000};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (access) begin
            err_d   = fault;
            rdata_d = (fault || c_we) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && access && c_we && !fault) begin
            mem_q[widx] <= (word & ~wmask) | (wdata_sh & wmask);
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule
